// File: rtl/mem_pkg.sv
// Shared types and helpers for the banked data memory: size encodings,
// FSM states, byte-enable generation and load extraction/extension.
package mem_pkg;

   localparam logic [1:0] MEM_BYTE = 2'b00;
   localparam logic [1:0] MEM_HALF = 2'b01;
   localparam logic [1:0] MEM_WORD = 2'b10;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_e;

   // Byte lanes touched by an access; little-endian, lane 0 = [7:0].
   function automatic logic [3:0] byte_mask(input logic [1:0] size, input logic [1:0] a);
      logic [3:0] m;
      m = 4'b0000;
      case (size)
         MEM_BYTE: m = 4'b0001 << a;
         MEM_HALF: m = a[1] ? 4'b1100 : 4'b0011;
         MEM_WORD: m = 4'b1111;
         default:  m = 4'b0000;
      endcase
      return m;
   endfunction

   // Pull the addressed byte/half out of a word and extend it to 32 bits.
   function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] size,
                                                input logic [1:0] a, input logic uns);
      logic [31:0] sh;
      logic [31:0] r;
      sh = word >> {a, 3'b000};
      case (size)
         MEM_BYTE: r = uns ? {24'h0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
         MEM_HALF: r = uns ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
         default:  r = word;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/data_memory_banked_if.sv
// Core-side request/response bus of the data memory.
interface data_memory_banked_if;
   logic        req;
   logic        mem_write;
   logic        mem_read;
   logic [1:0]  mem_size;
   logic        mem_unsigned;
   logic [31:0] addr;
   logic [31:0] write_data;
   logic        ready;
   logic        done;
   logic        error;
   logic [31:0] read_data;

   modport master (
      output req, mem_write, mem_read, mem_size, mem_unsigned, addr, write_data,
      input  ready, done, error, read_data
   );

   modport slave (
      input  req, mem_write, mem_read, mem_size, mem_unsigned, addr, write_data,
      output ready, done, error, read_data
   );
endinterface

// File: rtl/mem_lane_align.sv
// Combinational lane steering: store replication + byte mask, load
// extraction/extension and misalignment detection.
module mem_lane_align
   import mem_pkg::*;
(
   input  logic [1:0]  size,
   input  logic [1:0]  addr_lo,
   input  logic        uns,
   input  logic [31:0] wdata,
   input  logic [31:0] rword,
   output logic [31:0] wdata_rep,
   output logic [3:0]  be,
   output logic [31:0] rdata_ext,
   output logic        misalign
);

   // Replicate right-aligned store data across all lanes; the mask picks one.
   always_comb begin
      wdata_rep = wdata;
      misalign  = 1'b0;
      case (size)
         MEM_BYTE: wdata_rep = {4{wdata[7:0]}};
         MEM_HALF: begin
            wdata_rep = {2{wdata[15:0]}};
            misalign  = addr_lo[0];
         end
         MEM_WORD: misalign = (addr_lo != 2'b00);
         default:  wdata_rep = wdata;
      endcase
      be        = byte_mask(size, addr_lo);
      rdata_ext = load_extract(rword, size, addr_lo, uns);
   end

endmodule

// File: rtl/data_memory_banked.sv
// Clocked data memory with byte/half/word access, configurable wait
// states and a ready/done handshake for pipeline stalling.
module data_memory_banked
   import mem_pkg::*;
#(
   parameter int DEPTH_LOG2  = 8,
   parameter int WAIT_STATES = 0
) (
   input  logic                  clk,
   input  logic                  reset,
   data_memory_banked_if.slave   bus
);

   localparam int         DEPTH    = 2 ** DEPTH_LOG2;
   localparam int         AW       = DEPTH_LOG2 + 2;
   localparam logic [3:0] CNT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

   // Zero at time zero; never touched by reset.
   logic [31:0] mem_q [DEPTH] = '{default: 32'h0};

   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [1:0]  size_q, size_d;
   logic        uns_q, uns_d, rd_q, rd_d, wr_q, wr_d;
   logic        error_q, error_d;
   logic [31:0] rdata_q, rdata_d;

   logic          in_wait, accept, do_access, req_err, mem_we;
   logic [AW-1:0] acc_addr;
   logic [31:0]   acc_wdata, rword, wdata_rep, rdata_ext;
   logic [1:0]    acc_size;
   logic          acc_uns, acc_rd, acc_wr, misalign;
   logic [3:0]    be;
   logic          unused_addr_hi;

   // Upper address bits alias onto the array.
   assign unused_addr_hi = ^bus.addr[31:AW];

   // With no wait states the access uses the live bus at the accepting edge;
   // otherwise it uses the fields latched at acceptance.
   always_comb begin
      in_wait   = (state_q == WAIT);
      accept    = bus.req && !in_wait;
      acc_addr  = in_wait ? addr_q  : bus.addr[AW-1:0];
      acc_wdata = in_wait ? wdata_q : bus.write_data;
      acc_size  = in_wait ? size_q  : bus.mem_size;
      acc_uns   = in_wait ? uns_q   : bus.mem_unsigned;
      acc_rd    = in_wait ? rd_q    : bus.mem_read;
      acc_wr    = in_wait ? wr_q    : bus.mem_write;
      do_access = in_wait ? (cnt_q == 4'd0) : (accept && (WAIT_STATES == 0));
      rword     = mem_q[acc_addr[AW-1:2]];
   end

   mem_lane_align u_align (
      .size      (acc_size),
      .addr_lo   (acc_addr[1:0]),
      .uns       (acc_uns),
      .wdata     (acc_wdata),
      .rword     (rword),
      .wdata_rep (wdata_rep),
      .be        (be),
      .rdata_ext (rdata_ext),
      .misalign  (misalign)
   );

   // Error classification; read==write covers both-set and neither-set.
   always_comb begin
      req_err = misalign || (acc_size == 2'b11) || (acc_rd == acc_wr);
      mem_we  = do_access && acc_wr && !req_err && !reset;
   end

   // FSM, wait counter, request latch and response registers.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      size_d  = size_q;
      uns_d   = uns_q;
      rd_d    = rd_q;
      wr_d    = wr_q;
      if (accept) begin
         addr_d  = bus.addr[AW-1:0];
         wdata_d = bus.write_data;
         size_d  = bus.mem_size;
         uns_d   = bus.mem_unsigned;
         rd_d    = bus.mem_read;
         wr_d    = bus.mem_write;
      end
      case (state_q)
         IDLE, RESP: begin
            if (bus.req) begin
               state_d = (WAIT_STATES == 0) ? RESP : WAIT;
               cnt_d   = CNT_INIT;
            end else begin
               state_d = IDLE;
            end
         end
         WAIT: begin
            if (cnt_q == 4'd0) state_d = RESP;
            else               cnt_d   = cnt_q - 4'd1;
         end
         default: state_d = IDLE;
      endcase
      error_d = do_access && req_err;
      rdata_d = rdata_q;
      if (do_access) rdata_d = (req_err || acc_wr) ? 32'h0 : rdata_ext;
   end

   // Control/response state with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         addr_q  <= '0;
         wdata_q <= 32'h0;
         size_q  <= 2'b00;
         uns_q   <= 1'b0;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
         error_q <= 1'b0;
         rdata_q <= 32'h0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         size_q  <= size_d;
         uns_q   <= uns_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         error_q <= error_d;
         rdata_q <= rdata_d;
      end
   end

   // Byte-masked store into the word array.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i]) mem_q[acc_addr[AW-1:2]][8*i +: 8] <= wdata_rep[8*i +: 8];
         end
      end
   end

   assign bus.ready     = (state_q != WAIT);
   assign bus.done      = (state_q == RESP);
   assign bus.error     = error_q;
   assign bus.read_data = rdata_q;

endmodule

// File: tb/tb_data_memory_banked.sv
// Directed bench: one instance with no wait states, one with three.
module tb_data_memory_banked;
   import mem_pkg::*;

   logic clk = 1'b0;
   logic rst0 = 1'b1;
   logic rst3 = 1'b1;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   data_memory_banked_if b0 ();
   data_memory_banked_if b3 ();

   data_memory_banked #(.DEPTH_LOG2(8), .WAIT_STATES(0)) dut0 (.clk(clk), .reset(rst0), .bus(b0));
   data_memory_banked #(.DEPTH_LOG2(8), .WAIT_STATES(3)) dut3 (.clk(clk), .reset(rst3), .bus(b3));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drv0(input logic r, input logic w, input logic rd, input logic [1:0] sz,
                       input logic u, input logic [31:0] a, input logic [31:0] d);
      b0.req = r; b0.mem_write = w; b0.mem_read = rd; b0.mem_size = sz;
      b0.mem_unsigned = u; b0.addr = a; b0.write_data = d;
   endtask

   task automatic drv3(input logic r, input logic w, input logic rd, input logic [1:0] sz,
                       input logic u, input logic [31:0] a, input logic [31:0] d);
      b3.req = r; b3.mem_write = w; b3.mem_read = rd; b3.mem_size = sz;
      b3.mem_unsigned = u; b3.addr = a; b3.write_data = d;
   endtask

   // Issue one request on the wait-state instance and wait (bounded) for done.
   task automatic run3(input logic w, input logic rd, input logic [1:0] sz, input logic u,
                       input logic [31:0] a, input logic [31:0] d,
                       output logic got, output logic [31:0] rdv, output logic errv);
      got = 1'b0; rdv = 32'h0; errv = 1'b0;
      drv3(1'b1, w, rd, sz, u, a, d);
      tick();
      b3.req = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         if (b3.done === 1'b1) begin
            got = 1'b1; rdv = b3.read_data; errv = b3.error;
         end else begin
            tick();
         end
      end
      tick();
   endtask

   task automatic test_reset();
      drv0(0, 0, 0, MEM_BYTE, 0, 0, 0);
      drv3(0, 0, 0, MEM_BYTE, 0, 0, 0);
      rst0 = 1'b1; rst3 = 1'b1;
      repeat (3) tick();
      rst0 = 1'b0; rst3 = 1'b0;
      checks++; if (b0.ready !== 1'b1) begin errors++; $display("FAIL rst_ready0: got %b exp 1", b0.ready); end
      checks++; if (b0.done !== 1'b0) begin errors++; $display("FAIL rst_done0: got %b exp 0", b0.done); end
      checks++; if (b0.error !== 1'b0) begin errors++; $display("FAIL rst_error0: got %b exp 0", b0.error); end
      checks++; if (b0.read_data !== 32'h0) begin errors++; $display("FAIL rst_rdata0: got %h exp 0", b0.read_data); end
      checks++; if (b3.ready !== 1'b1) begin errors++; $display("FAIL rst_ready3: got %b exp 1", b3.ready); end
      checks++; if (b3.done !== 1'b0) begin errors++; $display("FAIL rst_done3: got %b exp 0", b3.done); end
   endtask

   task automatic test_back_to_back();
      drv0(1, 1, 0, MEM_WORD, 0, 32'h10, 32'hDEADBEEF);
      tick();
      checks++; if (b0.done !== 1'b1 || b0.error !== 1'b0) begin errors++; $display("FAIL b2b_store: done=%b err=%b exp 1/0", b0.done, b0.error); end
      drv0(1, 0, 1, MEM_WORD, 0, 32'h10, 32'h0);
      tick();
      checks++; if (b0.done !== 1'b1 || b0.read_data !== 32'hDEADBEEF) begin errors++; $display("FAIL b2b_ld_word: done=%b got %h exp deadbeef", b0.done, b0.read_data); end
      drv0(1, 0, 1, MEM_HALF, 1, 32'h12, 32'h0);
      tick();
      checks++; if (b0.done !== 1'b1 || b0.read_data !== 32'h0000DEAD) begin errors++; $display("FAIL b2b_ld_half_u: done=%b got %h exp 0000dead", b0.done, b0.read_data); end
      drv0(1, 0, 1, MEM_BYTE, 0, 32'h13, 32'h0);
      tick();
      checks++; if (b0.done !== 1'b1 || b0.read_data !== 32'hFFFFFFDE || b0.error !== 1'b0) begin errors++; $display("FAIL b2b_ld_byte_s: done=%b err=%b got %h exp ffffffde", b0.done, b0.error, b0.read_data); end
      drv0(0, 0, 0, MEM_BYTE, 0, 0, 0);
      tick();
      checks++; if (b0.done !== 1'b0 || b0.read_data !== 32'hFFFFFFDE) begin errors++; $display("FAIL b2b_idle: done=%b rdata=%h exp 0/ffffffde", b0.done, b0.read_data); end
   endtask

   task automatic test_byte_merge();
      drv0(1, 1, 0, MEM_WORD, 0, 32'h20, 32'h11223344); tick();
      drv0(1, 1, 0, MEM_BYTE, 0, 32'h21, 32'h000000AA); tick();
      drv0(1, 0, 1, MEM_WORD, 0, 32'h20, 32'h0); tick();
      checks++; if (b0.read_data !== 32'h1122AA44) begin errors++; $display("FAIL merge_word: got %h exp 1122aa44", b0.read_data); end
      drv0(1, 0, 1, MEM_BYTE, 0, 32'h21, 32'h0); tick();
      checks++; if (b0.read_data !== 32'hFFFFFFAA) begin errors++; $display("FAIL merge_byte_s: got %h exp ffffffaa", b0.read_data); end
      drv0(1, 0, 1, MEM_BYTE, 1, 32'h21, 32'h0); tick();
      checks++; if (b0.read_data !== 32'h000000AA) begin errors++; $display("FAIL merge_byte_u: got %h exp 000000aa", b0.read_data); end
      drv0(1, 0, 1, MEM_HALF, 0, 32'h22, 32'h0); tick();
      checks++; if (b0.read_data !== 32'h00001122) begin errors++; $display("FAIL merge_half_s: got %h exp 00001122", b0.read_data); end
      drv0(0, 0, 0, MEM_BYTE, 0, 0, 0); tick();
   endtask

   task automatic test_misaligned();
      drv0(1, 1, 0, MEM_HALF, 0, 32'h31, 32'h0000BEEF); tick();
      checks++; if (b0.done !== 1'b1 || b0.error !== 1'b1 || b0.read_data !== 32'h0) begin errors++; $display("FAIL mis_half_st: done=%b err=%b rdata=%h exp 1/1/0", b0.done, b0.error, b0.read_data); end
      drv0(1, 0, 1, MEM_WORD, 0, 32'h30, 32'h0); tick();
      checks++; if (b0.error !== 1'b0 || b0.read_data !== 32'h0) begin errors++; $display("FAIL mis_reload: err=%b rdata=%h exp 0/0", b0.error, b0.read_data); end
      drv0(1, 0, 1, MEM_WORD, 0, 32'h22, 32'h0); tick();
      checks++; if (b0.error !== 1'b1) begin errors++; $display("FAIL mis_word_ld: err=%b exp 1", b0.error); end
      drv0(1, 0, 1, 2'b11, 0, 32'h20, 32'h0); tick();
      checks++; if (b0.error !== 1'b1 || b0.done !== 1'b1) begin errors++; $display("FAIL illegal_size: err=%b done=%b exp 1/1", b0.error, b0.done); end
      drv0(0, 0, 0, MEM_BYTE, 0, 0, 0); tick();
   endtask

   task automatic test_alias_illegal();
      drv0(1, 1, 0, MEM_WORD, 0, 32'h400, 32'h12345678); tick();
      drv0(1, 0, 1, MEM_WORD, 0, 32'h000, 32'h0); tick();
      checks++; if (b0.read_data !== 32'h12345678) begin errors++; $display("FAIL alias_ld: got %h exp 12345678", b0.read_data); end
      drv0(1, 1, 1, MEM_WORD, 0, 32'h000, 32'hFFFFFFFF); tick();
      checks++; if (b0.error !== 1'b1 || b0.read_data !== 32'h0) begin errors++; $display("FAIL rdwr_both: err=%b rdata=%h exp 1/0", b0.error, b0.read_data); end
      drv0(1, 0, 0, MEM_WORD, 0, 32'h000, 32'hFFFFFFFF); tick();
      checks++; if (b0.error !== 1'b1) begin errors++; $display("FAIL rdwr_none: err=%b exp 1", b0.error); end
      drv0(1, 0, 1, MEM_WORD, 0, 32'h000, 32'h0); tick();
      checks++; if (b0.read_data !== 32'h12345678 || b0.error !== 1'b0) begin errors++; $display("FAIL illegal_noupd: got %h err=%b exp 12345678/0", b0.read_data, b0.error); end
      drv0(0, 0, 0, MEM_BYTE, 0, 0, 0); tick();
   endtask

   task automatic test_wait_states();
      logic got, ev;
      logic [31:0] rv;
      int nd;
      run3(1, 0, MEM_WORD, 0, 32'h8, 32'hCAFEF00D, got, rv, ev);
      checks++; if (got !== 1'b1 || ev !== 1'b0) begin errors++; $display("FAIL ws_store: got=%b err=%b exp 1/0", got, ev); end
      drv3(1, 0, 1, MEM_WORD, 0, 32'h8, 32'h0);
      tick();
      for (int c = 1; c <= 3; c++) begin
         checks++; if (b3.ready !== 1'b0 || b3.done !== 1'b0) begin errors++; $display("FAIL ws_cycle%0d: ready=%b done=%b exp 0/0", c, b3.ready, b3.done); end
         drv3(1, 1, 0, MEM_WORD, 0, 32'h8, 32'h0BAD0BAD);
         tick();
      end
      checks++; if (b3.ready !== 1'b1 || b3.done !== 1'b1 || b3.read_data !== 32'hCAFEF00D) begin errors++; $display("FAIL ws_cycle4: ready=%b done=%b rdata=%h exp 1/1/cafef00d", b3.ready, b3.done, b3.read_data); end
      drv3(0, 0, 0, MEM_BYTE, 0, 0, 0);
      nd = 0;
      for (int i = 0; i < 8; i++) begin tick(); if (b3.done === 1'b1) nd++; end
      checks++; if (nd != 0) begin errors++; $display("FAIL ws_extra_done: got %0d exp 0", nd); end
      run3(0, 1, MEM_WORD, 0, 32'h8, 32'h0, got, rv, ev);
      checks++; if (got !== 1'b1 || rv !== 32'hCAFEF00D) begin errors++; $display("FAIL ws_junk_ignored: got=%b rdata=%h exp 1/cafef00d", got, rv); end
   endtask

   task automatic test_reset_mid_wait();
      logic got, ev;
      logic [31:0] rv;
      int nd;
      drv3(1, 1, 0, MEM_BYTE, 0, 32'h40, 32'h00000055);
      tick();
      b3.req = 1'b0;
      tick();
      rst3 = 1'b1;
      tick();
      rst3 = 1'b0;
      checks++; if (b3.ready !== 1'b1 || b3.done !== 1'b0 || b3.read_data !== 32'h0) begin errors++; $display("FAIL rmw_state: ready=%b done=%b rdata=%h exp 1/0/0", b3.ready, b3.done, b3.read_data); end
      nd = 0;
      for (int i = 0; i < 6; i++) begin tick(); if (b3.done === 1'b1) nd++; end
      checks++; if (nd != 0) begin errors++; $display("FAIL rmw_no_done: got %0d exp 0", nd); end
      run3(0, 1, MEM_BYTE, 1, 32'h40, 32'h0, got, rv, ev);
      checks++; if (got !== 1'b1 || rv !== 32'h0 || ev !== 1'b0) begin errors++; $display("FAIL rmw_discarded: got=%b rdata=%h err=%b exp 1/0/0", got, rv, ev); end
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_byte_merge();
      test_misaligned();
      test_alias_illegal();
      test_wait_states();
      test_reset_mid_wait();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
